// File: rtl/toggle_sync_data_tx.sv
// Source-domain transmit side of a pulse-handshake CDC data synchronizer: captures one word,
// launches it, then waits for the returned ack. Define TOGGLE_SYNC_TX_TIMEOUT_EN for ack timeout.
module toggle_sync_data_tx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  sync_enable,
    output logic [DATA_WIDTH-1:0] sync_data,
    input  logic                  sync_ack,
    output logic                  busy,
    output logic                  timeout,
    output logic [15:0]           done_count
);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitAck
    } state_e;

    state_e                state_q, state_d;
    logic                  accept;
    logic                  ack_taken;
    logic                  abort;
    logic [DATA_WIDTH-1:0] sync_data_q;
    logic [15:0]           done_count_q;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; acks outside WAIT_ACK fall through unused
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (sync_ack || abort) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        in_ready    = (state_q == StIdle);
        sync_enable = (state_q == StLaunch);
        busy        = (state_q != StIdle);
    end

    assign accept    = in_valid & in_ready;
    assign ack_taken = (state_q == StWaitAck) & sync_ack;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_data_q  <= '0;
            done_count_q <= '0;
        end else begin
            if (accept) begin
                sync_data_q <= in_data;
            end
            if (ack_taken) begin
                done_count_q <= done_count_q + 16'd1;
            end
        end
    end

    assign sync_data  = sync_data_q;
    assign done_count = done_count_q;

`ifdef TOGGLE_SYNC_TX_TIMEOUT_EN
    localparam logic [15:0] TermCount = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q;

    // An ack on the terminal cycle wins over the abort
    assign abort = (state_q == StWaitAck) && !sync_ack && (wait_cnt_q == TermCount);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == StLaunch) begin
            wait_cnt_d = '0;
        end else if (state_q == StWaitAck && !sync_ack) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= abort;
        end
    end

    assign timeout = timeout_q;
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_sync_data_tx.sv
// Directed bench for toggle_sync_data_tx; launched words are checked against a queue of accepted
// words, completions against a modelled count.
module tb_toggle_sync_data_tx;

    localparam int unsigned DW = 8;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          sync_enable;
    logic [DW-1:0] sync_data;
    logic          sync_ack;
    logic          busy;
    logic          timeout;
    logic [15:0]   done_count;

    int            checks       = 0;
    int            errors       = 0;
    int            launches     = 0;
    int            exp_launches = 0;
    logic [15:0]   exp_count    = '0;
    logic [DW-1:0] sbq[$];

    toggle_sync_data_tx #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .sync_enable(sync_enable),
        .sync_data  (sync_data),
        .sync_ack   (sync_ack),
        .busy       (busy),
        .timeout    (timeout),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every launch pulse must present the oldest accepted word
    always @(negedge clk) begin
        if (reset_n && sync_enable) begin
            launches++;
            check("launch_has_entry", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) check("launch_word", 32'(sync_data), 32'(sbq.pop_front()));
        end
    end

    // Accept d, optionally ack during LAUNCH, ack on the last of wait_cycles WAIT_ACK cycles
    task automatic do_xfer(input logic [DW-1:0] d, input int wait_cycles, input bit hold,
                           input logic [DW-1:0] next_d, input bit launch_ack);
        check("idle_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        sbq.push_back(d);
        exp_launches++;
        tick();
        if (hold) in_data = next_d;
        else in_valid = 1'b0;
        check("launch_enable", 32'(sync_enable), 32'd1);
        check("launch_data", 32'(sync_data), 32'(d));
        check("launch_busy", 32'(busy), 32'd1);
        check("launch_not_ready", 32'(in_ready), 32'd0);
        if (launch_ack) sync_ack = 1'b1;
        tick();
        sync_ack = 1'b0;
        for (int i = 1; i <= wait_cycles; i++) begin
            check("wait_enable_low", 32'(sync_enable), 32'd0);
            check("wait_data_held", 32'(sync_data), 32'(d));
            check("wait_not_ready", 32'(in_ready), 32'd0);
            check("wait_count_held", 32'(done_count), 32'(exp_count));
            check("wait_no_timeout", 32'(timeout), 32'd0);
            if (i == wait_cycles) sync_ack = 1'b1;
            tick();
            sync_ack = 1'b0;
        end
        exp_count++;
        check("done_ready", 32'(in_ready), 32'd1);
        check("done_count", 32'(done_count), 32'(exp_count));
        check("done_no_timeout", 32'(timeout), 32'd0);
        check("done_data_held", 32'(sync_data), 32'(d));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sync_ack = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_enable", 32'(sync_enable), 32'd0);
        check("rst_data", 32'(sync_data), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_count", 32'(done_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single transfer; with the timeout compiled in the ack lands on the terminal cycle
`ifdef TOGGLE_SYNC_TX_TIMEOUT_EN
        do_xfer(8'hA5, 4, 1'b0, 8'h00, 1'b0);
`else
        do_xfer(8'hA5, 5, 1'b0, 8'h00, 1'b0);
`endif
        tick();
        check("single_no_timeout_after", 32'(timeout), 32'd0);

        // Stray ack in IDLE
        sync_ack = 1'b1;
        tick();
        sync_ack = 1'b0;
        check("stray_idle_busy", 32'(busy), 32'd0);
        check("stray_idle_enable", 32'(sync_enable), 32'd0);
        check("stray_idle_count", 32'(done_count), 32'(exp_count));

        // Stray ack in LAUNCH, real ack later
        do_xfer(8'h3C, 2, 1'b0, 8'h00, 1'b1);

        // Back-to-back with in_valid held; second word waits for the first ack
        do_xfer(8'h11, 4, 1'b1, 8'h22, 1'b0);
        do_xfer(8'h22, 4, 1'b0, 8'h00, 1'b0);
        check("b2b_count", 32'(done_count), 32'(exp_count));

`ifdef TOGGLE_SYNC_TX_TIMEOUT_EN
        // No ack: abort after TO WAIT_ACK cycles, timeout pulse in the first IDLE cycle
        in_valid = 1'b1;
        in_data  = 8'h5A;
        sbq.push_back(8'h5A);
        exp_launches++;
        tick();
        in_valid = 1'b0;
        check("to_launch", 32'(sync_enable), 32'd1);
        tick();
        for (int i = 0; i < int'(TO); i++) begin
            check("to_waiting", 32'(busy), 32'd1);
            check("to_no_pulse_yet", 32'(timeout), 32'd0);
            tick();
        end
        check("to_idle", 32'(in_ready), 32'd1);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_count", 32'(done_count), 32'(exp_count));
        tick();
        check("to_pulse_end", 32'(timeout), 32'd0);

        // Ack on the terminal cycle wins
        do_xfer(8'hC3, int'(TO), 1'b0, 8'h00, 1'b0);
        tick();
        check("term_ack_no_timeout", 32'(timeout), 32'd0);
`else
        // Without the timeout a long ack delay still completes normally
        do_xfer(8'hC3, 21, 1'b0, 8'h00, 1'b0);
`endif

        // Reset while in WAIT_ACK abandons the transfer
        in_valid = 1'b1;
        in_data  = 8'h77;
        sbq.push_back(8'h77);
        exp_launches++;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_rst_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        exp_count = '0;
        check("mid_rst_data", 32'(sync_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        check("mid_rst_count", 32'(done_count), 32'd0);
        sync_ack = 1'b1;
        tick();
        sync_ack = 1'b0;
        check("mid_rst_late_ack_count", 32'(done_count), 32'd0);
        check("mid_rst_late_ack_busy", 32'(busy), 32'd0);
        tick();
        check("mid_rst_no_timeout", 32'(timeout), 32'd0);

        // Wrap 0xFFFF -> 0x0000
        force dut.done_count_q = 16'hFFFF;
        tick();
        release dut.done_count_q;
        exp_count = 16'hFFFF;
        tick();
        check("wrap_preload", 32'(done_count), 32'(exp_count));
        do_xfer(8'hE1, 2, 1'b0, 8'h00, 1'b0);
        check("wrap_zero", 32'(done_count), 32'h0000);

        tick();
        check("launch_total", 32'(launches), 32'(exp_launches));
        check("queue_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_sync_data_tx.md
TOGGLE_SYNC_DATA_TX -- requirements
Module: toggle_sync_data_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the transferred word.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, number of WAIT_ACK cycles before abort; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  source-domain clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  producer offers in_data.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  producer word.
REQ-007 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port sync_enable  output  1  one-cycle launch pulse to the CDC data synchronizer enable input.
REQ-009 SHALL have port sync_data  output  DATA_WIDTH  held word to the CDC data synchronizer data input.
REQ-010 SHALL have port sync_ack  input  1  one-cycle acknowledge pulse returned by the CDC data synchronizer.
REQ-011 SHALL have port busy  output  1  transfer in flight (state != IDLE).
REQ-012 SHALL have port timeout  output  1  one-cycle abort pulse.
REQ-013 SHALL have port done_count  output  16  completed (acked) transfers, modulo 2^16.

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT_ACK.
REQ-015 in_ready SHALL be 1 only in IDLE, decoded from the state register.
REQ-016 In IDLE with in_valid=1, SHALL register in_data into sync_data and go to LAUNCH next cycle; handshake = in_valid & in_ready.
REQ-017 sync_enable SHALL be 1 for exactly the one cycle the FSM is in LAUNCH, i.e. one cycle after acceptance; LAUNCH always goes to WAIT_ACK.
REQ-018 sync_data SHALL stay constant from acceptance until the FSM returns to IDLE; it changes only on a new acceptance or reset.
REQ-019 In WAIT_ACK with sync_ack=1, SHALL increment done_count (wrap 0xFFFF->0x0000) and go to IDLE; in_ready rises the cycle after the ack.
REQ-020 sync_ack seen in IDLE or LAUNCH SHALL be ignored: no state change, no count.
REQ-021 in_valid while not IDLE SHALL be ignored; no word is queued.
REQ-022 Back-to-back throughput SHALL be one word per (3 + ack round-trip) cycles minimum; no launch SHALL occur while a previous launch is unacknowledged.

Reset
REQ-023 When reset_n=0 at a clk edge, state SHALL become IDLE, sync_enable=0, sync_data=0, timeout=0, done_count=0, wait counter=0.
REQ-024 Reset mid-transfer (LAUNCH or WAIT_ACK) SHALL abandon the transfer without a timeout pulse or count; in_ready=1 the first cycle after reset_n deasserts.

Configuration
REQ-025 Macro TOGGLE_SYNC_TX_TIMEOUT_EN SHALL compile in the ack timeout.
REQ-026 With the macro defined: a 16-bit counter clears on entering WAIT_ACK and increments each WAIT_ACK cycle without sync_ack; on the cycle it equals TIMEOUT_CYCLES-1 without ack, the FSM SHALL go to IDLE and timeout SHALL pulse 1 the following cycle; done_count unchanged.
REQ-027 With the macro defined, sync_ack in the same cycle as terminal count SHALL win: normal completion, no timeout.
REQ-028 Without the macro: no counter logic, timeout tied 0, WAIT_ACK waits indefinitely for sync_ack.

Verification
REQ-029 Single transfer: in_valid=1, in_data=0xA5 at cycle 0, sync_ack at cycle 6 -> sync_enable=1 only cycle 1, sync_data=0xA5 cycles 1-7, done_count=1, in_ready=1 at cycle 7.
REQ-030 Back-to-back: in_valid held with 0x11 then 0x22, ack 4 cycles after each launch -> exactly two sync_enable pulses, 0x22 accepted only after first ack, done_count=2.
REQ-031 Stray ack: sync_ack=1 in IDLE and in LAUNCH -> no state change, done_count unchanged, transfer completes on the later real ack.
REQ-032 Timeout (macro on, TIMEOUT_CYCLES=4): no ack -> FSM in IDLE after 4 WAIT_ACK cycles, timeout pulse one cycle later, done_count=0; ack on terminal cycle -> no timeout, done_count=1.
REQ-033 Reset in WAIT_ACK: reset_n=0 one cycle -> sync_data=0, busy=0, in_ready=1 next cycle, later ack ignored.
REQ-034 Wrap: preload 65535 completions (or force) then one more ack -> done_count=0x0000.
